// File: rtl/result_if.sv
// Handshake bundle between the result FIFO/serializer, the inference core and the Pi GPIO pins.
interface result_if #(
  parameter int NUM_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
);
  logic [8*NUM_BYTES-1:0]       in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         read_enable;
  logic [7:0]                   gpio_out;
  logic                         gpio_valid;
  logic                         gpio_last;
  logic [$clog2(FIFO_DEPTH):0]  words_pending;
  logic                         overflow;

  modport master (
    output in_data, in_valid, read_enable,
    input  in_ready, gpio_out, gpio_valid, gpio_last,
    input  words_pending, overflow
  );

  modport slave (
    input  in_data, in_valid, read_enable,
    output in_ready, gpio_out, gpio_valid, gpio_last,
    output words_pending, overflow
  );
endinterface

// File: rtl/result_tx.sv
// Result return path: word FIFO from the core, serialized bytewise onto the Pi GPIO bus.
module result_tx #(
  parameter int NUM_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic pi_clk,
  input  logic rst_n,
  result_if.slave bus
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(NUM_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          xfer;
  logic          at_last;
  logic          ovf;

  state_t        state;
  logic [W-1:0]  word;
  logic [IW-1:0] idx;
  logic          gvalid;
  logic          glast;

  assign full    = count == CW'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign push    = bus.in_valid && !full;
  assign xfer    = (state == SEND) && bus.read_enable;
  assign at_last = idx == IW'(NUM_BYTES - 1);
  assign pop     = !empty && ((state == IDLE) || (xfer && at_last));

  assign bus.in_ready      = !full;
  assign bus.words_pending = count;
  assign bus.overflow      = ovf;
  // word shifts right per byte, so the low byte is always the current one
  assign bus.gpio_out      = word[7:0];
  assign bus.gpio_valid    = gvalid;
  assign bus.gpio_last     = glast;

  always_ff @(posedge pi_clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (bus.in_valid && full)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      word   <= '0;
      idx    <= '0;
      gvalid <= 1'b0;
      glast  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state  <= SEND;
            word   <= mem[rd_ptr];
            idx    <= '0;
            gvalid <= 1'b1;
            glast  <= 1'b0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!at_last) begin
              idx   <= idx + 1'b1;
              word  <= word >> 8;
              glast <= idx == IW'(NUM_BYTES - 2);
            end else if (!empty) begin
              word  <= mem[rd_ptr];
              idx   <= '0;
              glast <= 1'b0;
            end else begin
              state  <= IDLE;
              gvalid <= 1'b0;
              glast  <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_result_tx.sv
// Self-checking bench for result_tx: scoreboard of expected bytes,
// consumed whenever the Pi side completes a byte transfer.
module tb_result_tx;
  localparam int NB = 4;
  localparam int FD = 4;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic pi_clk = 1'b0;
  logic rst_n  = 1'b0;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 pi_clk = ~pi_clk;

  result_if #(.NUM_BYTES(NB), .FIFO_DEPTH(FD)) bus ();

  result_tx #(.NUM_BYTES(NB), .FIFO_DEPTH(FD)) dut (
    .pi_clk (pi_clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    if (bus.in_ready)
      for (int i = 0; i < NB; i++)
        sb.push_back(exp_t'{w[8*i +: 8], (i == NB - 1)});
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.read_enable = 1'b1;
    while ((bus.gpio_valid || bus.words_pending != 0) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 1);
    chk("sb_empty", 64'(sb.size()), 0);
    bus.read_enable = 1'b0;
  endtask

  // a transfer happens on the next posedge; inputs are stable since posedge+1
  always @(negedge pi_clk) begin
    if (rst_n && bus.gpio_valid && bus.read_enable) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("sb_extra_byte", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("byte", bus.gpio_out, e.b);
        chk("last", bus.gpio_last, e.last);
      end
    end
  end

  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pb;
    int         n;

    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.read_enable = 1'b0;

    #12;
    chk("rst_valid", bus.gpio_valid, 0);
    chk("rst_out", bus.gpio_out, 0);
    chk("rst_last", bus.gpio_last, 0);
    chk("rst_pending", bus.words_pending, 0);
    chk("rst_ovf", bus.overflow, 0);
    #5 rst_n = 1'b1;
    cyc();
    chk("rst_ready", bus.in_ready, 1);

    // single word, continuous read, latency check
    bus.read_enable = 1'b1;
    push(32'hDDCCBBAA);
    chk("t2_lat_n", bus.gpio_valid, 0);
    cyc();
    chk("t2_lat_n1", bus.gpio_valid, 1);
    chk("t2_byte0", bus.gpio_out, 8'hAA);
    drain();
    chk("t2_idle", bus.gpio_valid, 0);

    // stalled reads: 1,0,0 repeating
    bus.read_enable = 1'b0;
    push(32'hDDCCBBAA);
    for (int i = 0; i < 24; i++) begin
      bus.read_enable = (i % 3 == 0);
      pv = bus.gpio_valid;
      pb = bus.gpio_out;
      pr = bus.read_enable;
      cyc();
      if (pv && !pr)
        chk("t3_hold", bus.gpio_out, pb);
    end
    drain();

    // back-to-back words with no bubble
    bus.read_enable = 1'b1;
    push(32'h11223344);
    push(32'h55667788);
    n = 0;
    while (!bus.gpio_valid && n < 10) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      chk("t4_nogap", bus.gpio_valid, 1);
      cyc();
    end
    chk("t4_end", bus.gpio_valid, 0);
    chk("t4_ovf", bus.overflow, 0);
    drain();

    // fill: one in SEND plus four queued, then an overflow attempt
    bus.read_enable = 1'b0;
    for (int i = 0; i < 5; i++)
      push(32'hA0A0A0A0 + 32'(i) * 32'h01010101);
    chk("t5_pending", bus.words_pending, 4);
    chk("t5_ready", bus.in_ready, 0);
    push(32'hEEEEEEEE);
    chk("t5_ovf", bus.overflow, 1);
    chk("t5_pending2", bus.words_pending, 4);
    drain();
    chk("t5_ovf_sticky", bus.overflow, 1);

    // asynchronous reset while a word is mid-send
    bus.read_enable = 1'b0;
    push(32'h13579BDF);
    push(32'h2468ACE0);
    cyc();
    chk("t1_sending", bus.gpio_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_valid", bus.gpio_valid, 0);
    chk("t1_out", bus.gpio_out, 0);
    chk("t1_last", bus.gpio_last, 0);
    chk("t1_pending", bus.words_pending, 0);
    chk("t1_ovf", bus.overflow, 0);
    sb.delete();
    #2 rst_n = 1'b1;
    cyc();
    chk("t1_ready", bus.in_ready, 1);
    cyc();
    chk("t1_no_resume", bus.gpio_valid, 0);

    // push and pop in the same cycle at depth 3
    for (int i = 0; i < 4; i++)
      push(32'h10203040 + 32'(i));
    chk("t6_pending", bus.words_pending, 3);
    bus.read_enable = 1'b1;
    n = 0;
    while (!bus.gpio_last && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_last_seen", bus.gpio_last, 1);
    push(32'hCAFEF00D);
    chk("t6_same", bus.words_pending, 3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
